dmem_resp_model: RTL and testbench

DMEM_RESP_MODEL -- requirements
Module: dmem_resp_model

---
 rtl/dmem_resp_model_if.sv | 23 ++
 rtl/dmem_resp_model.sv | 117 +++++++++++
 tb/tb_dmem_resp_model.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_model_if.sv
// Core-side data memory bus: request handshake plus single-cycle response beat.
// The core drives requests through master; the memory model answers through slave.
interface dmem_resp_model_if;
    logic        data_req_valid;
    logic        data_req_ready;
    logic        data_req_wr;
    logic [31:0] data_req_addr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_data;
    logic        data_rsp_valid;
    logic [31:0] data_rsp_data;
    logic        data_rsp_err;

    modport master (
        output data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
        input  data_req_ready, data_rsp_valid, data_rsp_data, data_rsp_err
    );

    modport slave (
        input  data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
        output data_req_ready, data_rsp_valid, data_rsp_data, data_rsp_err
    );
endinterface

// File: rtl/dmem_resp_model.sv
// Behavioural data memory with a fixed-latency, in-order response pipeline.
// Stores take effect at acceptance; loads snapshot the word at acceptance and return it later.
module dmem_resp_model #(
    parameter int          NWORDS    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1,
    parameter int          MAX_OUT   = 2,
    parameter int          WRITE_RSP = 0
) (
    input  logic              clk,
    input  logic              reset,
    dmem_resp_model_if.slave  bus,
    output logic [3:0]        outstanding
);

    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [31:0] mem [NWORDS];

    logic [31:0] offset;
    logic [31:0] word_idx;
    logic [1:0]  size_eff;
    logic [7:0]  base_mask;
    logic [7:0]  byte_mask;
    logic        in_window;
    logic        misaligned;
    logic        req_err;
    logic [31:0] load_word;
    logic        ready;
    logic        accept;
    logic        counted;
    logic        push_valid;
    logic        store_en;
    logic        rsp_fire;

    logic        pipe_valid [LATENCY];
    logic        pipe_err   [LATENCY];
    logic [31:0] pipe_data  [LATENCY];

    // Address decode: offsets below BASE_ADDR wrap to huge indices and fall out of the window.
    always_comb begin
        offset     = bus.data_req_addr - BASE_ADDR;
        word_idx   = offset >> 2;
        in_window  = (word_idx < 32'(NWORDS));
        size_eff   = (bus.data_req_size == 2'd3) ? 2'd2 : bus.data_req_size;
        case (size_eff)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
        byte_mask  = base_mask << bus.data_req_addr[1:0];
        misaligned = |byte_mask[7:4];
        req_err    = !in_window || misaligned;
        load_word  = in_window ? mem[word_idx[IDXW-1:0]] : 32'h0;
    end

    // A response leaving the pipeline frees its slot in the same cycle.
    always_comb begin
        rsp_fire           = pipe_valid[LATENCY-1];
        ready              = !reset && ((outstanding < 4'(MAX_OUT)) || rsp_fire);
        accept             = bus.data_req_valid && ready;
        counted            = !bus.data_req_wr || (WRITE_RSP != 0);
        push_valid         = accept && counted;
        store_en           = accept && bus.data_req_wr && !req_err;
        bus.data_req_ready = ready;
        bus.data_rsp_valid = rsp_fire;
        bus.data_rsp_data  = rsp_fire ? pipe_data[LATENCY-1] : 32'h0;
        bus.data_rsp_err   = rsp_fire && pipe_err[LATENCY-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NWORDS; w++) begin
                mem[w] <= 32'h0;
            end
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_mask[b]) begin
                    mem[word_idx[IDXW-1:0]][8*b +: 8] <= bus.data_req_data[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 holds the newest acceptance; the last stage drives the response beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= 32'h0;
            end
        end else begin
            pipe_valid[0] <= push_valid;
            pipe_err[0]   <= push_valid && req_err;
            pipe_data[0]  <= (push_valid && !bus.data_req_wr && !req_err) ? load_word : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= 4'd0;
        end else begin
            case ({push_valid, rsp_fire})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp_model.sv
// Scoreboard bench: the driver queues hand-computed responses at acceptance,
// and an independent monitor pops and compares each response beat on the falling edge.
module tb_dmem_resp_model;

    localparam int          LAT  = 3;
    localparam int          MAXO = 2;
    localparam int          NW   = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] outstanding;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       sb_q[$];

    dmem_resp_model_if bus ();

    dmem_resp_model #(
        .NWORDS    (NW),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT),
        .MAX_OUT   (MAXO),
        .WRITE_RSP (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                 input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
        int   waited = 0;
        exp_t e;
        bus.data_req_valid = 1'b1;
        bus.data_req_wr    = wr;
        bus.data_req_addr  = addr;
        bus.data_req_size  = size;
        bus.data_req_data  = wdata;
        @(negedge clk);
        while (!bus.data_req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.data_req_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL req_timeout: ready stayed %b, required 1 (addr %h)", bus.data_req_ready, addr);
            bus.data_req_valid = 1'b0;
            return;
        end
        e.data = exp_data;
        e.err  = exp_err;
        e.due  = cyc + LAT;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.data_req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: %0d responses pending, required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
        checkOutput("drained_outstanding", 32'(outstanding), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat must match the queue head in data, error flag and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            checkOutput("outstanding_max", 32'(outstanding <= 4'(MAXO)), 32'd1);
            if (bus.data_rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rsp: got data %h err %b, required no response",
                             bus.data_rsp_data, bus.data_rsp_err);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("rsp_data", bus.data_rsp_data, e.data);
                    checkOutput("rsp_err", 32'(bus.data_rsp_err), 32'(e.err));
                    checkOutput("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                checkOutput("idle_rsp_zero", bus.data_rsp_data | 32'(bus.data_rsp_err), 32'd0);
                if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                    e = sb_q.pop_front();
                    checks++;
                    failures++;
                    $display("[TB] FAIL missing_rsp: got no response, required data %h err %b at cycle %0d",
                             e.data, e.err, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pat [6] = '{1, 1, 0, 1, 1, 0};

        reset              = 1'b1;
        bus.data_req_valid = 1'b0;
        bus.data_req_wr    = 1'b0;
        bus.data_req_addr  = 32'h0;
        bus.data_req_size  = 2'd0;
        bus.data_req_data  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(bus.data_req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.data_rsp_valid), 32'd0);
        checkOutput("reset_outstanding", 32'(outstanding), 32'd0);
        reset = 1'b0;

        $display("[TB] basic load/store and byte lanes");
        applyStimulus(1'b0, BASE + 32'd4,  2'd2, 32'h0,          32'h0,          1'b0);
        applyStimulus(1'b1, BASE + 32'd8,  2'd2, 32'hDEADBEEF,   32'h0,          1'b0);
        applyStimulus(1'b0, BASE + 32'd8,  2'd2, 32'h0,          32'hDEADBEEF,   1'b0);
        applyStimulus(1'b1, BASE + 32'd9,  2'd0, 32'h0000_5A00,  32'h0,          1'b0);
        applyStimulus(1'b0, BASE + 32'd8,  2'd2, 32'h0,          32'hDEAD5AEF,   1'b0);
        applyStimulus(1'b1, BASE + 32'd10, 2'd1, 32'h1234_0000,  32'h0,          1'b0);
        applyStimulus(1'b0, BASE + 32'd8,  2'd2, 32'h0,          32'h12345AEF,   1'b0);

        $display("[TB] window and alignment errors");
        applyStimulus(1'b0, BASE + 32'd64, 2'd2, 32'h0,          32'h0,          1'b1);
        applyStimulus(1'b0, BASE - 32'd4,  2'd2, 32'h0,          32'h0,          1'b1);
        applyStimulus(1'b1, BASE,          2'd2, 32'h11223344,   32'h0,          1'b0);
        applyStimulus(1'b1, BASE + 32'd3,  2'd1, 32'hFFFF_FFFF,  32'h0,          1'b1);
        applyStimulus(1'b1, BASE + 32'd2,  2'd3, 32'hFFFF_FFFF,  32'h0,          1'b1);
        applyStimulus(1'b1, BASE + 32'd64, 2'd2, 32'hFFFF_FFFF,  32'h0,          1'b1);
        applyStimulus(1'b0, BASE,          2'd2, 32'h0,          32'h11223344,   1'b0);
        applyStimulus(1'b0, BASE + 32'd2,  2'd1, 32'h0,          32'h11223344,   1'b0);
        applyStimulus(1'b0, BASE + 32'd1,  2'd2, 32'h0,          32'h0,          1'b1);

        $display("[TB] load snapshot ahead of same-word store");
        applyStimulus(1'b0, BASE + 32'd8,  2'd2, 32'h0,          32'h12345AEF,   1'b0);
        applyStimulus(1'b1, BASE + 32'd8,  2'd2, 32'hCAFEF00D,   32'h0,          1'b0);
        applyStimulus(1'b0, BASE + 32'd8,  2'd2, 32'h0,          32'hCAFEF00D,   1'b0);
        applyStimulus(1'b1, BASE + 32'd12, 2'd3, 32'hA5A5A5A5,   32'h0,          1'b0);
        applyStimulus(1'b0, BASE + 32'd12, 2'd2, 32'h0,          32'hA5A5A5A5,   1'b0);
        applyStimulus(1'b0, BASE + 32'd60, 2'd2, 32'h0,          32'h0,          1'b0);
        waitDrain();

        $display("[TB] ready throttling with valid held high");
        bus.data_req_valid = 1'b1;
        bus.data_req_wr    = 1'b0;
        bus.data_req_addr  = BASE + 32'd12;
        bus.data_req_size  = 2'd2;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            @(negedge clk);
            checkOutput("ready_pattern", 32'(bus.data_req_ready), 32'(pat[i]));
            if (i == 2) checkOutput("outstanding_full", 32'(outstanding), 32'd2);
            if (bus.data_req_ready) begin
                e.data = 32'hA5A5A5A5;
                e.err  = 1'b0;
                e.due  = cyc + LAT;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        bus.data_req_valid = 1'b0;
        waitDrain();

        $display("[TB] reset with requests in flight");
        applyStimulus(1'b0, BASE + 32'd8,  2'd2, 32'h0, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, BASE + 32'd12, 2'd2, 32'h0, 32'hA5A5A5A5, 1'b0);
        checkOutput("pre_reset_outstanding", 32'(outstanding), 32'd2);
        #2;
        reset = 1'b1;
        sb_q.delete();
        #1;
        checkOutput("midreset_outstanding", 32'(outstanding), 32'd0);
        checkOutput("midreset_rsp_valid", 32'(bus.data_rsp_valid), 32'd0);
        checkOutput("midreset_ready", 32'(bus.data_req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, BASE + 32'd8,  2'd2, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, BASE + 32'd12, 2'd2, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, BASE,          2'd2, 32'h0, 32'h0, 1'b0);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
